frv_mmio_bridge: RTL and testbench

Routes the core's data-memory request/response channel either to main memory or to the single-cycle MMIO port of the timer/counter block. Addresses inside the MMIO window become one-cycle `mmio_en` strobes; all other addresses pass through to the memory port. The block sits directly upstream of the counters block and downstream of the core's load/store unit. It preserves response ordering between the two targets and rejects MMIO accesses the counters block cannot express.

---
 rtl/frv_mmio_pkg.sv | 26 ++
 rtl/frv_mmio_decode.sv | 22 ++
 rtl/frv_mmio_bridge.sv | 171 +++++++++++++++++
 tb/tb_frv_mmio_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mmio_pkg.sv
// Shared definitions for the core-to-MMIO bridge: FSM states, default window
// constants and the timer register offsets used by both decode and software headers.
package frv_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mmio_state_t;

  localparam logic [31:0] MMIO_DEFAULT_BASE = 32'h0000_1000;
  localparam logic [31:0] MMIO_DEFAULT_MASK = 32'hFFFF_F000;

  localparam logic [31:0] MTIME_LO_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] MTIME_HI_OFFSET    = 32'h0000_0004;
  localparam logic [31:0] MTIMECMP_LO_OFFSET = 32'h0000_0008;
  localparam logic [31:0] MTIMECMP_HI_OFFSET = 32'h0000_000C;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/frv_mmio_decode.sv
// Combinational window decode plus the access checks a word-only MMIO target
// needs: word alignment and full-word strobes on writes.
module frv_mmio_decode
  import frv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE = MMIO_DEFAULT_BASE,
  parameter logic [31:0] MASK = MMIO_DEFAULT_MASK
) (
  input  logic        req,
  input  logic        wen,
  input  logic [3:0]  strb,
  input  logic [31:0] addr,
  output logic        hit,
  output logic        bad
);

  assign hit = req && in_window(addr, BASE, MASK);

  // Reads ignore the strobes; writes must cover the whole word.
  assign bad = (addr[1:0] != 2'b00) || (wen && (strb != 4'b1111));

endmodule

// File: rtl/frv_mmio_bridge.sv
// Steers data-memory requests either to main memory or to the single-cycle
// timer/counter MMIO port, keeping responses in request order.
module frv_mmio_bridge
  import frv_mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE_ADDR      = MMIO_DEFAULT_BASE,
  parameter logic [31:0] MMIO_BASE_MASK      = MMIO_DEFAULT_MASK,
  parameter int unsigned MEM_MAX_OUTSTANDING = 2
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        cpu_req,
  output logic        cpu_gnt,
  input  logic        cpu_wen,
  input  logic [3:0]  cpu_strb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_recv,
  input  logic        cpu_ack,
  output logic        cpu_error,
  output logic [31:0] cpu_rdata,

  output logic        mem_req,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,

  output logic        mmio_en,
  output logic        mmio_wen,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_error
);

  localparam logic [1:0] MAX_CNT = 2'(MEM_MAX_OUTSTANDING);

  mmio_state_t state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        wen_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic hit;
  logic bad;
  logic idle;
  logic mmio_gnt;
  logic mem_fire;
  logic resp_fire;

  frv_mmio_decode #(
    .BASE (MMIO_BASE_ADDR),
    .MASK (MMIO_BASE_MASK)
  ) u_decode (
    .req  (cpu_req),
    .wen  (cpu_wen),
    .strb (cpu_strb),
    .addr (cpu_addr),
    .hit  (hit),
    .bad  (bad)
  );

  assign idle = (state_reg == IDLE);
  // Waiting for cnt==0 keeps the MMIO response behind any memory responses still in flight.
  assign mmio_gnt = hit && idle && (cnt_reg == 2'd0);

  assign mem_wen   = cpu_wen;
  assign mem_strb  = cpu_strb;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  assign mmio_addr  = addr_reg;
  assign mmio_wdata = wdata_reg;

  assign mem_fire  = mem_req && mem_gnt;
  assign resp_fire = mem_recv && mem_ack;

  always_comb begin
    state_next = state_reg;
    mem_req    = cpu_req && !hit && idle && (cnt_reg < MAX_CNT);
    cpu_gnt    = hit ? mmio_gnt : (mem_req && mem_gnt);
    mmio_en    = 1'b0;
    mmio_wen   = 1'b0;
    cpu_recv   = mem_recv;
    cpu_error  = mem_error;
    cpu_rdata  = mem_rdata;
    mem_ack    = cpu_ack;

    case (state_reg)
      IDLE: begin
        if (mmio_gnt) begin
          state_next = bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mmio_en    = 1'b1;
        mmio_wen   = wen_reg;
        state_next = WAIT;
      end
      WAIT: begin
        state_next = RESP;
      end
      RESP: begin
        cpu_recv  = 1'b1;
        cpu_error = err_reg;
        cpu_rdata = rdata_reg;
        mem_ack   = 1'b0;
        if (cpu_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({mem_fire, resp_fire})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wen_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      if (mmio_gnt) begin
        wen_reg   <= cpu_wen;
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
        if (bad) begin
          rdata_reg <= 32'd0;
          err_reg   <= 1'b1;
        end
      end
      // Write responses carry no data, so the captured word is zeroed.
      if (state_reg == WAIT) begin
        rdata_reg <= wen_reg ? 32'd0 : mmio_rdata;
        err_reg   <= mmio_error;
      end
    end
  end

endmodule

// File: tb/tb_frv_mmio_bridge.sv
// Scoreboard bench for frv_mmio_bridge with a small timer target model and
// a hand-driven memory responder.
module tb_frv_mmio_bridge;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cpu_req, cpu_gnt, cpu_wen;
  logic [3:0]  cpu_strb;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_recv, cpu_ack, cpu_error;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_recv, mem_ack, mem_error;
  logic [31:0] mem_rdata;
  logic        mmio_en, mmio_wen;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_error;

  frv_mmio_bridge dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .cpu_req    (cpu_req),
    .cpu_gnt    (cpu_gnt),
    .cpu_wen    (cpu_wen),
    .cpu_strb   (cpu_strb),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_recv   (cpu_recv),
    .cpu_ack    (cpu_ack),
    .cpu_error  (cpu_error),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_recv   (mem_recv),
    .mem_ack    (mem_ack),
    .mem_error  (mem_error),
    .mem_rdata  (mem_rdata),
    .mmio_en    (mmio_en),
    .mmio_wen   (mmio_wen),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .mmio_error (mmio_error)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          gcyc;
    bit          mmio;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   wen_cnt = 0;
  int   last_en_cyc = -1;
  bit   head_seen = 0;
  int   mem_done_cyc = -1;

  // Timer target: free-running mtime and two compare words, registered read.
  logic [31:0] mtime, cmp_lo, cmp_hi;
  always @(posedge g_clk) begin
    if (g_reset) begin
      mtime      <= 32'd0;
      cmp_lo     <= 32'h0000_0100;
      cmp_hi     <= 32'hDEAD_BEEF;
      mmio_rdata <= 32'd0;
    end else begin
      mtime <= mtime + 32'd1;
      if (mmio_en) begin
        if (mmio_wen) begin
          if (mmio_addr[3:0] == 4'h8) cmp_lo <= mmio_wdata;
          if (mmio_addr[3:0] == 4'hC) cmp_hi <= mmio_wdata;
        end
        case (mmio_addr[3:0])
          4'h0:    mmio_rdata <= mtime;
          4'h8:    mmio_rdata <= cmp_lo;
          4'hC:    mmio_rdata <= cmp_hi;
          default: mmio_rdata <= 32'd0;
        endcase
      end
    end
  end

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", nm, act, cyc);
    end
  endtask

  always @(negedge g_clk) begin
    if (mmio_en) begin
      en_cnt++;
      last_en_cyc = cyc;
      if (mmio_wen) wen_cnt++;
    end
  end

  // Response monitor: compares every cycle the DUT presents a response.
  always @(negedge g_clk) begin
    if (!g_reset && cpu_recv) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_recv: got cpu_recv=1 with nothing outstanding, required 0 (cycle %0d)", cyc);
      end else begin
        if (!head_seen) begin
          head_seen = 1;
          if (sb[0].lat >= 0) chk("recv_latency", 32'(cyc - sb[0].gcyc), 32'(sb[0].lat));
        end
        chk("cpu_error", {31'd0, cpu_error}, {31'd0, sb[0].err});
        chk("cpu_rdata", cpu_rdata, sb[0].rdata);
        if (sb[0].mmio) chk("mem_ack_in_resp", {31'd0, mem_ack}, 32'd0);
        if (cpu_ack) begin
          void'(sb.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [3:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                       input bit use_mtime, input int lat, input bit is_mmio, input bit push,
                       output int gcyc);
    exp_t e;
    bit   got;
    got  = 0;
    gcyc = -1;
    @(posedge g_clk); #1;
    cpu_req   = 1'b1;
    cpu_wen   = wen;
    cpu_strb  = strb;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge g_clk);
      if (cpu_gnt) begin
        got  = 1;
        gcyc = cyc;
        if (is_mmio) chk("mem_req_on_mmio", {31'd0, mem_req}, 32'd0);
        else         chk("mem_addr_pass", mem_addr, addr);
        if (push) begin
          e.err   = exp_err;
          e.rdata = use_mtime ? mtime + 32'd1 : exp_rdata;
          e.lat   = lat;
          e.gcyc  = gcyc;
          e.mmio  = is_mmio;
          sb.push_back(e);
        end
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL grant_timeout: addr %h got no cpu_gnt, required a grant", addr);
    end
    @(posedge g_clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL resp_timeout: got %0d responses pending, required 0", sb.size());
      sb.delete();
      head_seen = 0;
    end
  endtask

  task automatic run_mmio(input logic wen, input logic [3:0] strb, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata, input bit use_mtime, input int lat);
    int en0, wen0, g;
    en0  = en_cnt;
    wen0 = wen_cnt;
    issue(wen, strb, addr, wdata, exp_err, exp_rdata, use_mtime, lat, 1'b1, 1'b1, g);
    wait_done();
    chk("mmio_en_pulses", 32'(en_cnt - en0), (lat == 3) ? 32'd1 : 32'd0);
    chk("mmio_wen_pulses", 32'(wen_cnt - wen0), (lat == 3 && wen) ? 32'd1 : 32'd0);
    if (lat == 3) chk("mmio_en_cycle", 32'(last_en_cyc - g), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, en0;
    g_reset   = 1'b1;
    cpu_req   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_strb  = 4'h0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    cpu_ack   = 1'b1;
    mem_gnt   = 1'b1;
    mem_recv  = 1'b0;
    mem_error = 1'b0;
    mem_rdata = 32'd0;
    mmio_error = 1'b0;
    repeat (3) @(posedge g_clk);
    #1 g_reset = 1'b0;

    @(negedge g_clk);
    chk("rst_cpu_recv", {31'd0, cpu_recv}, 32'd0);
    chk("rst_cpu_error", {31'd0, cpu_error}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mmio_en", {31'd0, mmio_en}, 32'd0);
    chk("rst_mmio_wen", {31'd0, mmio_wen}, 32'd0);
    chk("rst_mmio_addr", mmio_addr, 32'd0);
    chk("rst_mmio_wdata", mmio_wdata, 32'd0);

    // Read mtime low after free-running cycles; strobes are ignored on reads.
    repeat (10) @(posedge g_clk);
    run_mmio(1'b0, 4'b0000, 32'h0000_1000, 32'd0, 1'b0, 32'd0, 1'b1, 3);

    // Full-word write then read back of mtimecmp high.
    run_mmio(1'b1, 4'b1111, 32'h0000_100C, 32'd0, 1'b0, 32'd0, 1'b0, 3);
    run_mmio(1'b0, 4'b1111, 32'h0000_100C, 32'd0, 1'b0, 32'd0, 1'b0, 3);

    // Early errors: partial-strobe write and misaligned read.
    run_mmio(1'b1, 4'b0011, 32'h0000_1008, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 1);
    run_mmio(1'b0, 4'b1111, 32'h0000_1002, 32'd0, 1'b1, 32'd0, 1'b0, 1);

    // Two outstanding memory reads, a stalled third, then an MMIO read held off.
    issue(1'b0, 4'b1111, 32'h8000_0000, 32'd0, 1'b0, 32'hA5A5_0001, 1'b0, -1, 1'b0, 1'b1, g);
    issue(1'b0, 4'b1111, 32'h8000_0000, 32'd0, 1'b1, 32'hA5A5_0002, 1'b0, -1, 1'b0, 1'b1, g);
    @(posedge g_clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h8000_0004;
    repeat (4) begin
      @(negedge g_clk);
      chk("stall_mem_req", {31'd0, mem_req}, 32'd0);
      chk("stall_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    end
    @(posedge g_clk); #1;
    cpu_req = 1'b0;
    fork
      issue(1'b0, 4'b1111, 32'h0000_1004, 32'd0, 1'b0, 32'd0, 1'b0, 3, 1'b1, 1'b1, g);
      begin
        repeat (3) @(posedge g_clk);
        #1;
        mem_recv  = 1'b1;
        mem_error = 1'b0;
        mem_rdata = 32'hA5A5_0001;
        @(posedge g_clk); #1;
        mem_error = 1'b1;
        mem_rdata = 32'hA5A5_0002;
        @(negedge g_clk);
        mem_done_cyc = cyc;
        @(posedge g_clk); #1;
        mem_recv  = 1'b0;
        mem_error = 1'b0;
        mem_rdata = 32'd0;
      end
    join
    chk("mmio_gnt_after_mem", 32'(g - mem_done_cyc), 32'd1);
    wait_done();

    // Response held for five cycles without ack.
    cpu_ack = 1'b0;
    issue(1'b0, 4'b1111, 32'h0000_1008, 32'd0, 1'b0, 32'h0000_0100, 1'b0, 3, 1'b1, 1'b1, g);
    repeat (7) @(posedge g_clk);
    #1 cpu_ack = 1'b1;
    wait_done();
    @(negedge g_clk);
    chk("recv_drop_after_ack", {31'd0, cpu_recv}, 32'd0);

    // Reset while in WAIT: response dropped, no further strobe.
    issue(1'b0, 4'b1111, 32'h0000_1000, 32'd0, 1'b0, 32'd0, 1'b0, 3, 1'b1, 1'b0, g);
    @(posedge g_clk); #1;
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    en0 = en_cnt;
    @(negedge g_clk);
    chk("wrst_cpu_recv", {31'd0, cpu_recv}, 32'd0);
    chk("wrst_cpu_error", {31'd0, cpu_error}, 32'd0);
    chk("wrst_cpu_rdata", cpu_rdata, 32'd0);
    chk("wrst_mmio_en", {31'd0, mmio_en}, 32'd0);
    chk("wrst_mmio_addr", mmio_addr, 32'd0);
    repeat (6) @(negedge g_clk);
    chk("wrst_no_mmio_en", 32'(en_cnt - en0), 32'd0);

    // Bridge recovers; target compare word is back at its reset value.
    run_mmio(1'b0, 4'b1111, 32'h0000_100C, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
